ex_mem_wb_buf: RTL and testbench

Parametrised EX→MEM→WB pipeline buffer with a valid/ready handshake and a wait-state memory interface. It holds one instruction leaving the execute stage and decodes its control word into memory-read and memory-write strobes. It drives the memory request until acknowledged, then presents a one-cycle writeback record selecting ALU or memory data. It sits between the ALU and the register-file write port, and replaces the fixed 16-bit, single-cycle writeback buffer.

---
 rtl/ex_mem_wb_buf_pkg.sv | 31 +++
 rtl/ex_mem_wb_buf_timeout_cnt.sv | 41 ++++
 rtl/ex_mem_wb_buf.sv | 179 +++++++++++++++++
 tb/tb_ex_mem_wb_buf.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_mem_wb_buf_pkg.sv
// Shared opcode constants, state encoding and control-word decode for ex_mem_wb_buf.
package ex_mem_wb_buf_pkg;

    localparam logic [3:0] OP_LOAD   = 4'b1100;
    localparam logic [3:0] OP_STORE  = 4'b1000;
    localparam logic [3:0] OP_BRANCH = 4'b0100;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        MEM   = 2'd1,
        DONE  = 2'd2
    } state_t;

    typedef struct packed {
        logic is_load;
        logic is_store;
        logic wb_en;
    } dec_t;

    function automatic dec_t decode_op(input logic [3:0] op);
        dec_t d;
        case (op)
            OP_LOAD:   d = '{is_load: 1'b1, is_store: 1'b0, wb_en: 1'b1};
            OP_STORE:  d = '{is_load: 1'b0, is_store: 1'b1, wb_en: 1'b0};
            OP_BRANCH: d = '{is_load: 1'b0, is_store: 1'b0, wb_en: 1'b0};
            default:   d = '{is_load: 1'b0, is_store: 1'b0, wb_en: 1'b1};
        endcase
        return d;
    endfunction

endpackage

// File: rtl/ex_mem_wb_buf_timeout_cnt.sv
// Memory wait counter: clear on entry to MEM, count wait cycles, flag the last allowed one.
module ex_mem_timeout_cnt #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic in_clr,
    input  logic in_en,
    output logic out_tc
);

    localparam int               CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TERM  = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear wins, then saturating increment.
    always_comb begin
        if (in_clr) begin
            cnt_d = '0;
        end else if (in_en && (cnt_q != TERM)) begin
            cnt_d = cnt_q + ONE;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign out_tc = (cnt_q == TERM);

endmodule

// File: rtl/ex_mem_wb_buf.sv
// EX->MEM->WB buffer with valid/ready intake, wait-state memory port and one-cycle writeback.
// Define EX_MEM_WB_BUF_FWD_EN to add the forwarding / load-hazard outputs.
module ex_mem_wb_buf
    import ex_mem_wb_buf_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int CNTRL_W = 16,
    parameter int REG_W   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic               CLOCK,
    input  logic               in_rst,
    input  logic               in_valid,
    output logic               out_ready,
    input  logic [CNTRL_W-1:0] in_cntrl_ex,
    input  logic [DATA_W-1:0]  in_alu,
    input  logic [DATA_W-1:0]  in_op1_data,
    input  logic               in_flush,
    output logic               out_mem_req,
    output logic               out_cntrl_mem_read,
    output logic               out_cntrl_mem_write,
    output logic [DATA_W-1:0]  out_addr_mem,
    output logic [DATA_W-1:0]  out_data_mem,
    input  logic               in_mem_ack,
    input  logic [DATA_W-1:0]  in_mem_rdata,
    output logic               out_wb_valid,
    output logic               out_cntrl_m5,
    output logic [REG_W-1:0]   out_wb_reg,
    output logic [DATA_W-1:0]  out_m5,
    output logic               out_err
`ifdef EX_MEM_WB_BUF_FWD_EN
    ,
    output logic               out_fwd_valid,
    output logic [REG_W-1:0]   out_fwd_reg,
    output logic [DATA_W-1:0]  out_fwd_data,
    output logic               out_fwd_pending
`endif
);

    state_t             state_q, state_d;
    logic               is_load_q, is_load_d;
    logic               is_store_q, is_store_d;
    logic [REG_W-1:0]   wb_reg_q, wb_reg_d;
    logic [DATA_W-1:0]  alu_q, alu_d;
    logic [DATA_W-1:0]  op1_q, op1_d;
    logic               flushed_q, flushed_d;
    logic [DATA_W-1:0]  m5_q, m5_d;
    logic               cntrl_m5_q, cntrl_m5_d;
    logic               wb_valid_q, wb_valid_d;
    logic               err_q, err_d;
    logic               cnt_clr_s, cnt_en_s, cnt_tc_s;
    dec_t               dec_s;
    logic               unused_cntrl_s;

    assign unused_cntrl_s = ^in_cntrl_ex[CNTRL_W-5-REG_W:0];

    ex_mem_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_timeout_cnt (
        .clk    (CLOCK),
        .rst    (in_rst),
        .in_clr (cnt_clr_s),
        .in_en  (cnt_en_s),
        .out_tc (cnt_tc_s)
    );

    // Next-state and capture logic for the single held entry.
    always_comb begin
        state_d    = state_q;
        is_load_d  = is_load_q;
        is_store_d = is_store_q;
        wb_reg_d   = wb_reg_q;
        alu_d      = alu_q;
        op1_d      = op1_q;
        flushed_d  = flushed_q;
        m5_d       = m5_q;
        cntrl_m5_d = cntrl_m5_q;
        wb_valid_d = 1'b0;
        err_d      = err_q;
        cnt_clr_s  = 1'b0;
        cnt_en_s   = 1'b0;
        dec_s      = decode_op(in_cntrl_ex[CNTRL_W-1 -: 4]);
        case (state_q)
            EMPTY, DONE: begin
                if (in_flush) begin
                    state_d   = EMPTY;
                    flushed_d = 1'b0;
                end else if (in_valid) begin
                    is_load_d  = dec_s.is_load;
                    is_store_d = dec_s.is_store;
                    wb_reg_d   = in_cntrl_ex[CNTRL_W-5 -: REG_W];
                    alu_d      = in_alu;
                    op1_d      = in_op1_data;
                    flushed_d  = 1'b0;
                    if (dec_s.is_load || dec_s.is_store) begin
                        state_d   = MEM;
                        cnt_clr_s = 1'b1;
                    end else begin
                        state_d    = DONE;
                        wb_valid_d = dec_s.wb_en;
                        m5_d       = in_alu;
                        cntrl_m5_d = 1'b1;
                    end
                end else begin
                    state_d = EMPTY;
                end
            end
            MEM: begin
                // A flush only marks the entry; the bus access still runs to completion.
                flushed_d = flushed_q | in_flush;
                if (in_mem_ack) begin
                    state_d = DONE;
                    if (is_load_q && !flushed_d) begin
                        wb_valid_d = 1'b1;
                        m5_d       = in_mem_rdata;
                        cntrl_m5_d = 1'b0;
                    end else begin
                        wb_valid_d = 1'b0;
                    end
                end else if (cnt_tc_s) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                end else begin
                    cnt_en_s = 1'b1;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
    end

    // Pipeline entry and writeback registers.
    always_ff @(posedge CLOCK or posedge in_rst) begin
        if (in_rst) begin
            state_q    <= EMPTY;
            is_load_q  <= 1'b0;
            is_store_q <= 1'b0;
            wb_reg_q   <= '0;
            alu_q      <= '0;
            op1_q      <= '0;
            flushed_q  <= 1'b0;
            m5_q       <= '0;
            cntrl_m5_q <= 1'b0;
            wb_valid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            is_load_q  <= is_load_d;
            is_store_q <= is_store_d;
            wb_reg_q   <= wb_reg_d;
            alu_q      <= alu_d;
            op1_q      <= op1_d;
            flushed_q  <= flushed_d;
            m5_q       <= m5_d;
            cntrl_m5_q <= cntrl_m5_d;
            wb_valid_q <= wb_valid_d;
            err_q      <= err_d;
        end
    end

    assign out_ready           = (state_q != MEM);
    assign out_mem_req         = (state_q == MEM);
    assign out_cntrl_mem_read  = (state_q == MEM) && is_load_q;
    assign out_cntrl_mem_write = (state_q == MEM) && is_store_q;
    assign out_addr_mem        = (state_q == MEM) ? alu_q : '0;
    assign out_data_mem        = ((state_q == MEM) && is_store_q) ? op1_q : '0;
    assign out_wb_valid        = wb_valid_q;
    assign out_cntrl_m5        = cntrl_m5_q;
    assign out_wb_reg          = wb_reg_q;
    assign out_m5              = m5_q;
    assign out_err             = err_q;

`ifdef EX_MEM_WB_BUF_FWD_EN
    assign out_fwd_valid   = wb_valid_q;
    assign out_fwd_reg     = wb_reg_q;
    assign out_fwd_data    = m5_q;
    assign out_fwd_pending = (state_q == MEM) && is_load_q && !flushed_q;
`endif

endmodule

// File: tb/tb_ex_mem_wb_buf.sv
// Scoreboard bench for ex_mem_wb_buf: directed stimulus pushes expectations, a monitor checks them.
module tb_ex_mem_wb_buf;

    logic        CLOCK = 1'b0;
    logic        in_rst;
    logic        in_valid;
    logic        out_ready;
    logic [15:0] in_cntrl_ex;
    logic [15:0] in_alu;
    logic [15:0] in_op1_data;
    logic        in_flush;
    logic        out_mem_req;
    logic        out_cntrl_mem_read;
    logic        out_cntrl_mem_write;
    logic [15:0] out_addr_mem;
    logic [15:0] out_data_mem;
    logic        in_mem_ack;
    logic [15:0] in_mem_rdata;
    logic        out_wb_valid;
    logic        out_cntrl_m5;
    logic [3:0]  out_wb_reg;
    logic [15:0] out_m5;
    logic        out_err;
`ifdef EX_MEM_WB_BUF_FWD_EN
    logic        out_fwd_valid;
    logic [3:0]  out_fwd_reg;
    logic [15:0] out_fwd_data;
    logic        out_fwd_pending;
`endif

    typedef struct packed {
        logic [15:0] data;
        logic        sel;
        logic [3:0]  rg;
    } wb_t;

    typedef struct packed {
        logic        rd;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] data;
        logic [31:0] len;
    } mem_t;

    wb_t  wb_q[$];
    mem_t mem_q[$];
    int   checks   = 0;
    int   failures = 0;

    always #5 CLOCK = ~CLOCK;

    ex_mem_wb_buf #(.DATA_W(16), .CNTRL_W(16), .REG_W(4), .TIMEOUT(3)) dut (
        .CLOCK               (CLOCK),
        .in_rst              (in_rst),
        .in_valid            (in_valid),
        .out_ready           (out_ready),
        .in_cntrl_ex         (in_cntrl_ex),
        .in_alu              (in_alu),
        .in_op1_data         (in_op1_data),
        .in_flush            (in_flush),
        .out_mem_req         (out_mem_req),
        .out_cntrl_mem_read  (out_cntrl_mem_read),
        .out_cntrl_mem_write (out_cntrl_mem_write),
        .out_addr_mem        (out_addr_mem),
        .out_data_mem        (out_data_mem),
        .in_mem_ack          (in_mem_ack),
        .in_mem_rdata        (in_mem_rdata),
        .out_wb_valid        (out_wb_valid),
        .out_cntrl_m5        (out_cntrl_m5),
        .out_wb_reg          (out_wb_reg),
        .out_m5              (out_m5),
        .out_err             (out_err)
`ifdef EX_MEM_WB_BUF_FWD_EN
        ,
        .out_fwd_valid       (out_fwd_valid),
        .out_fwd_reg         (out_fwd_reg),
        .out_fwd_data        (out_fwd_data),
        .out_fwd_pending     (out_fwd_pending)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic push_wb(input logic [15:0] data, input logic sel, input logic [3:0] rg);
        wb_t w;
        w.data = data;
        w.sel  = sel;
        w.rg   = rg;
        wb_q.push_back(w);
    endtask

    task automatic push_mem(input logic rd, input logic wr, input logic [15:0] addr,
                            input logic [15:0] data, input logic [31:0] len);
        mem_t m;
        m.rd   = rd;
        m.wr   = wr;
        m.addr = addr;
        m.data = data;
        m.len  = len;
        mem_q.push_back(m);
    endtask

    task automatic step();
        @(posedge CLOCK);
        #2;
    endtask

    task automatic issue(input logic [15:0] c, input logic [15:0] a, input logic [15:0] d);
        in_valid    = 1'b1;
        in_cntrl_ex = c;
        in_alu      = a;
        in_op1_data = d;
        step();
        in_valid    = 1'b0;
    endtask

    task automatic ack_after(input int waits, input logic [15:0] rdata);
        for (int i = 0; i < waits; i++) step();
        in_mem_ack   = 1'b1;
        in_mem_rdata = rdata;
        step();
        in_mem_ack   = 1'b0;
        in_mem_rdata = 16'h0000;
    endtask

    // Monitor: compares memory requests and writebacks against the scoreboard queues.
    initial begin : monitor
        int   run;
        mem_t m;
        wb_t  w;
        run = 0;
        forever begin
            @(posedge CLOCK);
            #1;
            if (in_rst) begin
                if (run > 0 && mem_q.size() > 0) begin
                    m = mem_q.pop_front();
                    check("mem_abort_len", 32'(run), m.len);
                end
                run = 0;
            end else begin
                if (out_mem_req) begin
                    run++;
                    if (mem_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL mem_unexpected actual=req required=no_req");
                    end else begin
                        m = mem_q[0];
                        check("mem_rd",   32'(out_cntrl_mem_read),  32'(m.rd));
                        check("mem_wr",   32'(out_cntrl_mem_write), 32'(m.wr));
                        check("mem_addr", 32'(out_addr_mem),        32'(m.addr));
                        check("mem_data", 32'(out_data_mem),        32'(m.data));
                    end
                end else begin
                    check("strobe_idle", 32'({out_cntrl_mem_read, out_cntrl_mem_write}), 32'(0));
                    if (run > 0 && mem_q.size() > 0) begin
                        m = mem_q.pop_front();
                        check("mem_len", 32'(run), m.len);
                    end
                    run = 0;
                end
                if (out_wb_valid) begin
                    if (wb_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL wb_unexpected actual=valid required=none m5=0x%0h", out_m5);
                    end else begin
                        w = wb_q.pop_front();
                        check("wb_m5",  32'(out_m5),       32'(w.data));
                        check("wb_sel", 32'(out_cntrl_m5), 32'(w.sel));
                        check("wb_reg", 32'(out_wb_reg),   32'(w.rg));
`ifdef EX_MEM_WB_BUF_FWD_EN
                        check("fwd_valid", 32'(out_fwd_valid), 32'(1));
                        check("fwd_data",  32'(out_fwd_data),  32'(w.data));
                        check("fwd_reg",   32'(out_fwd_reg),   32'(w.rg));
`endif
                    end
                end
            end
        end
    end

    // Hard stop if the stimulus ever stalls.
    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "bench watchdog expired");
    end

    // Directed stimulus.
    initial begin : stimulus
        in_rst       = 1'b1;
        in_valid     = 1'b0;
        in_cntrl_ex  = 16'h0000;
        in_alu       = 16'h0000;
        in_op1_data  = 16'h0000;
        in_flush     = 1'b0;
        in_mem_ack   = 1'b0;
        in_mem_rdata = 16'h0000;
        step();
        check("rst_ready", 32'(out_ready),    32'(1));
        check("rst_req",   32'(out_mem_req),  32'(0));
        check("rst_wb",    32'(out_wb_valid), 32'(0));
        check("rst_err",   32'(out_err),      32'(0));
        check("rst_m5",    32'(out_m5),       32'(0));
        in_rst = 1'b0;
        step();

        // Back-to-back ALU ops.
        push_wb(16'h0F50, 1'b1, 4'd1);
        push_wb(16'h0FF0, 1'b1, 4'd4);
        issue(16'h0120, 16'h0F50, 16'h0000);
        issue(16'h0448, 16'h0FF0, 16'h0000);
        step();
        step();

        // Store with two wait states; the ack lands on the timeout edge and must win.
        push_mem(1'b0, 1'b1, 16'h0002, 16'h1CD4, 32'd3);
        issue(16'h8892, 16'h0002, 16'h1CD4);
        ack_after(2, 16'h0000);
        check("err_ack_wins", 32'(out_err), 32'(0));

        // Zero-wait load.
        push_mem(1'b1, 1'b0, 16'h0002, 16'h0000, 32'd1);
        push_wb(16'h1CD4, 1'b0, 4'd10);
        issue(16'hCA92, 16'h0002, 16'h0000);
        ack_after(0, 16'h1CD4);
        step();

        // Branch: no request, no writeback.
        issue(16'h4740, 16'h1234, 16'h5678);
        check("branch_ready", 32'(out_ready), 32'(1));
        step();
        check("branch_ready_hold", 32'(out_ready), 32'(1));

        // Flush dominates valid in EMPTY.
        in_valid    = 1'b1;
        in_flush    = 1'b1;
        in_cntrl_ex = 16'h0330;
        in_alu      = 16'hBEEF;
        step();
        in_valid = 1'b0;
        in_flush = 1'b0;
        check("flush_no_accept", 32'(out_wb_valid), 32'(0));
        step();

        // Load never acked: times out after three request cycles.
        push_mem(1'b1, 1'b0, 16'h0010, 16'h0000, 32'd3);
        issue(16'hC300, 16'h0010, 16'h0000);
        check("err_pre_timeout", 32'(out_err), 32'(0));
        for (int i = 0; i < 3; i++) step();
        check("err_timeout", 32'(out_err), 32'(1));
        check("ready_after_timeout", 32'(out_ready), 32'(1));
        push_wb(16'h00AA, 1'b1, 4'd7);
        issue(16'h0700, 16'h00AA, 16'h0000);
        step();
        check("err_sticky", 32'(out_err), 32'(1));

        // Flush during a load wait: request holds until ack, no writeback.
        push_mem(1'b1, 1'b0, 16'h0020, 16'h0000, 32'd3);
        issue(16'hC500, 16'h0020, 16'h0000);
`ifdef EX_MEM_WB_BUF_FWD_EN
        check("fwd_pending_set", 32'(out_fwd_pending), 32'(1));
        check("fwd_pending_reg", 32'(out_fwd_reg),     32'(5));
`endif
        step();
        in_flush = 1'b1;
        step();
        in_flush = 1'b0;
        check("flush_req_held", 32'(out_mem_req), 32'(1));
`ifdef EX_MEM_WB_BUF_FWD_EN
        check("fwd_pending_clr", 32'(out_fwd_pending), 32'(0));
`endif
        in_mem_ack = 1'b1;
        step();
        in_mem_ack = 1'b0;
        check("flush_ready", 32'(out_ready), 32'(1));
        step();

        // Asynchronous reset in the middle of a request.
        push_mem(1'b1, 1'b0, 16'h0030, 16'h0000, 32'd2);
        issue(16'hC600, 16'h0030, 16'h0000);
        step();
        #3;
        in_rst = 1'b1;
        #1;
        check("arst_req",   32'(out_mem_req),        32'(0));
        check("arst_rd",    32'(out_cntrl_mem_read), 32'(0));
        check("arst_addr",  32'(out_addr_mem),       32'(0));
        check("arst_ready", 32'(out_ready),          32'(1));
        check("arst_err",   32'(out_err),            32'(0));
        step();
        in_rst = 1'b0;
        step();
        step();
        step();

        check("wb_q_drained",  32'(wb_q.size()),  32'(0));
        check("mem_q_drained", 32'(mem_q.size()), 32'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
